if_id_stage_reg: RTL and testbench



---
 rtl/core_pkg.sv | 14 +
 rtl/skid_buffer.sv | 68 ++++++
 rtl/if_id_stage_reg.sv | 72 +++++++
 tb/tb_if_id_stage_reg.sv | 217 +++++++++++++++++++++
 4 files changed

// File: rtl/core_pkg.sv
// Shared RV32I core definitions: default field widths, the canonical NOP and the IF/ID payload.
package core_pkg;

    localparam int XLEN_DEF = 32;
    localparam int ILEN_DEF = 32;

    localparam logic [31:0] RV_NOP = 32'h0000_0013;

    typedef struct packed {
        logic [XLEN_DEF-1:0] pc;
        logic [ILEN_DEF-1:0] insn;
    } if_id_t;

endpackage

// File: rtl/skid_buffer.sv
// Generic 2-entry valid/ready skid buffer on a packed payload; in_ready is a pure register output.
module skid_buffer #(
    parameter int           W       = 64,
    parameter logic [W-1:0] RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         flush,
    input  logic         in_valid,
    output logic         in_ready,
    input  logic [W-1:0] in_data,
    output logic         out_valid,
    input  logic         out_ready,
    output logic [W-1:0] out_data
);

    logic         main_v_q, main_v_d;
    logic [W-1:0] main_q, main_d;
    logic         skid_v_q, skid_v_d;
    logic [W-1:0] skid_q, skid_d;
    logic         accept;
    logic         consume;

    assign in_ready  = !skid_v_q;
    assign out_valid = main_v_q;
    assign out_data  = main_q;
    assign accept    = in_valid && !skid_v_q;
    assign consume   = main_v_q && out_ready;

    always_comb begin
        main_v_d = main_v_q;
        main_d   = main_q;
        skid_v_d = skid_v_q;
        skid_d   = skid_q;
        if (flush) begin
            main_v_d = 1'b0;
            skid_v_d = 1'b0;
        end else if (!main_v_q || consume) begin
            // A full skid always drains first; accept is already blocked then.
            if (skid_v_q) begin
                main_v_d = 1'b1;
                main_d   = skid_q;
                skid_v_d = 1'b0;
            end else begin
                main_v_d = accept;
                if (accept) main_d = in_data;
            end
        end else if (accept) begin
            skid_v_d = 1'b1;
            skid_d   = in_data;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            main_v_q <= 1'b0;
            main_q   <= RST_VAL;
            skid_v_q <= 1'b0;
            skid_q   <= RST_VAL;
        end else begin
            main_v_q <= main_v_d;
            main_q   <= main_d;
            skid_v_q <= skid_v_d;
            skid_q   <= skid_d;
        end
    end

endmodule

// File: rtl/if_id_stage_reg.sv
// IF/ID pipeline register: PC + instruction with valid/ready, optional skid buffer, flush to NOP.
module if_id_stage_reg
    import core_pkg::*;
#(
    parameter int              XLEN     = XLEN_DEF,
    parameter int              ILEN     = ILEN_DEF,
    parameter logic [ILEN-1:0] NOP_INSN = RV_NOP,
    parameter bit              SKID_EN  = 1'b1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            in_valid,
    output logic            in_ready,
    input  logic [XLEN-1:0] in_pc,
    input  logic [ILEN-1:0] in_insn,
    input  logic            flush,
    output logic            out_valid,
    input  logic            out_ready,
    output logic [XLEN-1:0] out_pc,
    output logic [ILEN-1:0] out_insn
);

    localparam int           W           = XLEN + ILEN;
    localparam logic [W-1:0] RST_PAYLOAD = {{XLEN{1'b0}}, NOP_INSN};

    logic         head_v;
    logic [W-1:0] head_data;

    generate
        if (SKID_EN) begin : g_skid
            skid_buffer #(
                .W       (W),
                .RST_VAL (RST_PAYLOAD)
            ) u_skid (
                .clk       (clk),
                .rst       (rst),
                .flush     (flush),
                .in_valid  (in_valid),
                .in_ready  (in_ready),
                .in_data   ({in_pc, in_insn}),
                .out_valid (head_v),
                .out_ready (out_ready),
                .out_data  (head_data)
            );
        end else begin : g_single
            logic         main_v_q;
            logic [W-1:0] main_q;

            assign in_ready  = out_ready || !main_v_q;
            assign head_v    = main_v_q;
            assign head_data = main_q;

            always_ff @(posedge clk) begin
                if (rst) begin
                    main_v_q <= 1'b0;
                    main_q   <= RST_PAYLOAD;
                end else if (flush) begin
                    main_v_q <= 1'b0;
                end else if (in_ready) begin
                    main_v_q <= in_valid;
                    if (in_valid) main_q <= {in_pc, in_insn};
                end
            end
        end
    endgenerate

    // Invalid slots always show NOP so decode never sees a stale instruction.
    assign out_valid = head_v;
    assign out_pc    = head_data[W-1:ILEN];
    assign out_insn  = head_v ? head_data[ILEN-1:0] : NOP_INSN;

endmodule

// File: tb/tb_if_id_stage_reg.sv
// Bench for if_id_stage_reg: skid and single-register builds against a FIFO reference model.
module tb_if_id_stage_reg;
    import core_pkg::*;

    logic        clk;
    logic        rst;
    logic        flush;
    logic        iv   [2];
    logic        ordy [2];
    logic [31:0] ipc  [2];
    logic [31:0] iins [2];

    wire         ir0, ir1, ov0, ov1;
    wire  [31:0] opc0, opc1, oins0, oins1;

    int          n_pass = 0;
    int          n_tot  = 0;

    if_id_t      mq0[$];
    if_id_t      mq1[$];
    logic [31:0] last_pc  [2];
    logic        accepted [2];
    logic [31:0] cur_pc   [2];
    logic [31:0] cur_ins  [2];

    if_id_stage_reg #(.SKID_EN(1'b1)) u_dut0 (
        .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(ir0),
        .in_pc(ipc[0]), .in_insn(iins[0]), .flush(flush),
        .out_valid(ov0), .out_ready(ordy[0]), .out_pc(opc0), .out_insn(oins0)
    );

    if_id_stage_reg #(.SKID_EN(1'b0)) u_dut1 (
        .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(ir1),
        .in_pc(ipc[1]), .in_insn(iins[1]), .flush(flush),
        .out_valid(ov1), .out_ready(ordy[1]), .out_pc(opc1), .out_insn(oins1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic        d_ov  (int k); return k == 0 ? ov0   : ov1;   endfunction
    function automatic logic        d_ir  (int k); return k == 0 ? ir0   : ir1;   endfunction
    function automatic logic [31:0] d_opc (int k); return k == 0 ? opc0  : opc1;  endfunction
    function automatic logic [31:0] d_oins(int k); return k == 0 ? oins0 : oins1; endfunction

    function automatic int msize(int k);
        return k == 0 ? mq0.size() : mq1.size();
    endfunction

    function automatic if_id_t mhead(int k);
        return k == 0 ? mq0[0] : mq1[0];
    endfunction

    // Skid build holds up to two entries; single build holds one and may pass through on consume.
    function automatic logic mready(int k);
        if (k == 0) return msize(0) < 2;
        return ordy[1] || msize(1) == 0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_tot++;
        if (act !== exp) $display("FAIL %s actual=%h required=%h", name, act, exp);
        else n_pass++;
    endtask

    task automatic step();
        logic acc [2];
        logic pop [2];
        #1;
        for (int k = 0; k < 2; k++) begin
            if (!rst) begin
                chk($sformatf("dut%0d out_valid", k), 32'(d_ov(k)), 32'(msize(k) > 0));
                chk($sformatf("dut%0d out_insn", k), d_oins(k), msize(k) > 0 ? mhead(k).insn : RV_NOP);
                chk($sformatf("dut%0d out_pc", k), d_opc(k), msize(k) > 0 ? mhead(k).pc : last_pc[k]);
                chk($sformatf("dut%0d in_ready", k), 32'(d_ir(k)), 32'(mready(k)));
            end
            acc[k] = !rst && iv[k] && mready(k);
            pop[k] = msize(k) > 0 && ordy[k];
        end
        @(posedge clk);
        for (int k = 0; k < 2; k++) begin
            if (rst || flush) begin
                if (k == 0) mq0.delete(); else mq1.delete();
                if (rst) last_pc[k] = 32'h0;
            end else begin
                if (pop[k]) begin
                    if (k == 0) void'(mq0.pop_front()); else void'(mq1.pop_front());
                end
                if (acc[k]) begin
                    if (k == 0) mq0.push_back('{pc: ipc[0], insn: iins[0]});
                    else        mq1.push_back('{pc: ipc[1], insn: iins[1]});
                end
            end
            if (msize(k) > 0) last_pc[k] = mhead(k).pc;
            accepted[k] = acc[k];
        end
        @(negedge clk);
    endtask

    task automatic drive0(input logic v, input logic [31:0] pc, input logic [31:0] insn, input logic r);
        iv[0] = v; ipc[0] = pc; iins[0] = insn; ordy[0] = r;
    endtask

    initial begin
        logic pat [8];
        rst = 1'b1; flush = 1'b0;
        for (int k = 0; k < 2; k++) begin
            iv[k] = 1'b0; ordy[k] = 1'b1; ipc[k] = '0; iins[k] = '0;
            last_pc[k] = '0; accepted[k] = 1'b0;
        end
        @(negedge clk);

        // Reset then idle
        repeat (3) step();
        rst = 1'b0;
        #1;
        chk("reset out_valid", 32'(ov0), 32'h0);
        chk("reset out_insn", oins0, 32'h0000_0013);
        chk("reset out_pc", opc0, 32'h0);
        chk("reset in_ready", 32'(ir0), 32'h1);
        chk("reset in_ready single", 32'(ir1), 32'h1);
        step();

        // Streaming with out_ready=1
        drive0(1'b1, 32'h0, 32'h0050_0093, 1'b1); step();
        chk("stream pc0", opc0, 32'h0);
        chk("stream insn0", oins0, 32'h0050_0093);
        drive0(1'b1, 32'h4, 32'h0010_8133, 1'b1); step();
        chk("stream pc4", opc0, 32'h4);
        chk("stream ready", 32'(ir0), 32'h1);
        drive0(1'b1, 32'h8, 32'hFE00_0EE3, 1'b1); step();
        chk("stream insn8", oins0, 32'hFE00_0EE3);
        drive0(1'b0, 32'h0, 32'h0, 1'b1); step();

        // Backpressure fills main then skid
        drive0(1'b1, 32'h10, 32'h0000_1111, 1'b0); step();
        drive0(1'b1, 32'h14, 32'h0000_2222, 1'b0); step();
        chk("bp ready low", 32'(ir0), 32'h0);
        chk("bp head", opc0, 32'h10);
        drive0(1'b1, 32'h18, 32'h0000_3333, 1'b0); step();
        drive0(1'b1, 32'h18, 32'h0000_3333, 1'b1); step();
        chk("bp drain 14", opc0, 32'h14);
        drive0(1'b1, 32'h18, 32'h0000_3333, 1'b1); step();
        chk("bp drain 18", opc0, 32'h18);
        chk("bp drain 18 insn", oins0, 32'h0000_3333);
        drive0(1'b0, 32'h0, 32'h0, 1'b1); step();

        // Flush with both entries full
        drive0(1'b1, 32'h30, 32'h0000_4444, 1'b0); step();
        drive0(1'b1, 32'h34, 32'h0000_5555, 1'b0); step();
        flush = 1'b1;
        drive0(1'b1, 32'h20, 32'h0000_6666, 1'b0); step();
        flush = 1'b0;
        chk("flush out_valid", 32'(ov0), 32'h0);
        chk("flush out_insn", oins0, 32'h0000_0013);
        chk("flush in_ready", 32'(ir0), 32'h1);
        chk("flush pc held", opc0, 32'h30);
        drive0(1'b1, 32'h40, 32'h0000_7777, 1'b1); step();
        chk("post flush pc", opc0, 32'h40);
        chk("post flush valid", 32'(ov0), 32'h1);
        drive0(1'b0, 32'h0, 32'h0, 1'b1); step();

        // Reset mid-operation
        drive0(1'b1, 32'h50, 32'h0000_8888, 1'b0); step();
        drive0(1'b1, 32'h54, 32'h0000_9999, 1'b0); step();
        rst = 1'b1;
        drive0(1'b0, 32'h0, 32'h0, 1'b0); step();
        rst = 1'b0;
        #1;
        chk("midrst out_valid", 32'(ov0), 32'h0);
        chk("midrst out_insn", oins0, 32'h0000_0013);
        chk("midrst in_ready", 32'(ir0), 32'h1);
        step();
        chk("midrst no stale", 32'(ov0), 32'h0);

        // Single-register build with out_ready toggling under a continuous stream
        pat = '{1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b1};
        cur_pc[1] = 32'h100; cur_ins[1] = 32'h0000_0113;
        foreach (pat[i]) begin
            iv[1] = 1'b1; ipc[1] = cur_pc[1]; iins[1] = cur_ins[1]; ordy[1] = pat[i];
            #1;
            if (msize(1) > 0) chk("single ready follows out_ready", 32'(ir1), 32'(pat[i]));
            step();
            if (accepted[1]) begin
                cur_pc[1]  = cur_pc[1] + 32'h4;
                cur_ins[1] = cur_ins[1] + 32'h100;
            end
        end
        iv[1] = 1'b0; ordy[1] = 1'b1; step();

        // Randomized traffic on both builds
        for (int k = 0; k < 2; k++) begin
            cur_pc[k] = 32'h1000 * (k + 1); cur_ins[k] = $urandom;
        end
        for (int c = 0; c < 3000; c++) begin
            rst   = ($urandom_range(0, 199) == 0);
            flush = ($urandom_range(0, 31) == 0);
            for (int k = 0; k < 2; k++) begin
                iv[k]   = !rst && ($urandom_range(0, 3) != 0);
                ordy[k] = ($urandom_range(0, 2) != 0);
                ipc[k]  = cur_pc[k];
                iins[k] = cur_ins[k];
            end
            step();
            for (int k = 0; k < 2; k++) begin
                if (accepted[k]) begin
                    cur_pc[k]  = cur_pc[k] + 32'h4;
                    cur_ins[k] = $urandom;
                end
            end
        end

        $display("%0d/%0d checks passed", n_pass, n_tot);
        $finish;
    end

endmodule
